// File: rtl/imem_fetch_router.sv
// Instruction-fetch router: steers fetches to ITCM or IAXI, tracks up to MAX_OUTSTANDING in-flight reads, drops stale data after flush.
// Latency: request outputs are combinational from pc. Data returns with the source latency, forwarded combinationally from the source.
// Backpressure: pc_ready drops on flush, auto-load, full tracker, target switch with reads in flight, or IAXI not ready.
module imem_fetch_router #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INSTR_WIDTH     = 32,
  parameter int                    HAS_ITCM        = 1,
  parameter logic [ADDR_WIDTH-1:0] ITCM_START_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ITCM_SIZE       = 32'h0001_0000,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   instr_read_data_valid,
  output logic                   instr_itcm_access,
  output logic [ADDR_WIDTH-1:0]  instr_itcm_addr,
  input  logic [INSTR_WIDTH-1:0] instr_itcm_read_data,
  input  logic                   instr_itcm_read_data_valid,
  input  logic                   itcm_auto_load,
  output logic                   IAXI_access,
  output logic [ADDR_WIDTH-1:0]  IAXI_addr,
  input  logic                   IAXI_ready,
  input  logic [INSTR_WIDTH-1:0] IAXI_read_data,
  input  logic                   IAXI_read_data_valid
);

  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam bit              ITCM_EN = (HAS_ITCM != 0);
  // One extra bit keeps the upper bound from wrapping at the top of memory.
  localparam logic [ADDR_WIDTH:0] ITCM_LO = {1'b0, ITCM_START_ADDR};
  localparam logic [ADDR_WIDTH:0] ITCM_HI = {1'b0, ITCM_START_ADDR} + {1'b0, ITCM_SIZE};

  typedef enum logic {
    TGT_ITCM = 1'b0,
    TGT_IAXI = 1'b1
  } tgt_e;

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  tgt_e          cur_tgt;

  logic              tgt_itcm;
  tgt_e              tgt;
  logic              issue;
  logic              resp;
  logic [ADDR_WIDTH:0] pc_ext;

  assign pc_ext = {1'b0, pc};

  // Address decode and request acceptance.
  always_comb begin
    tgt_itcm = ITCM_EN && (pc_ext >= ITCM_LO) && (pc_ext < ITCM_HI);
    tgt      = tgt_itcm ? TGT_ITCM : TGT_IAXI;
    // Mixing targets with reads in flight could reorder returns, so wait for drain.
    pc_ready = cpu_rstn && !flush && !itcm_auto_load && (out_cnt < MAX_CNT)
               && ((out_cnt == '0) || (tgt == cur_tgt))
               && (tgt_itcm || IAXI_ready);
    issue    = pc_valid && pc_ready;
  end

  // Request strobes; addresses follow pc directly.
  always_comb begin
    instr_itcm_access = issue && tgt_itcm;
    IAXI_access       = issue && !tgt_itcm;
    instr_itcm_addr   = pc;
    IAXI_addr         = pc;
  end

  // Response detection and forwarding; loader traffic on IAXI is not ours.
  always_comb begin
    resp = 1'b0;
    if (out_cnt != '0) begin
      if (cur_tgt == TGT_ITCM) resp = instr_itcm_read_data_valid;
      else                     resp = IAXI_read_data_valid && !itcm_auto_load;
    end
    instr_read_data_valid = resp && (drop_cnt == '0) && !flush;
    instr_read_data       = '0;
    if (instr_read_data_valid)
      instr_read_data = (cur_tgt == TGT_ITCM) ? instr_itcm_read_data : IAXI_read_data;
  end

  // In-flight counter and current target of the in-flight group.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      out_cnt <= '0;
      cur_tgt <= TGT_ITCM;
    end else begin
      out_cnt <= out_cnt + CW'(issue) - CW'(resp);
      if (issue) cur_tgt <= tgt;
    end
  end

  // Stale-response counter: every read still in flight after a flush is discarded.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= out_cnt - CW'(resp);
    end else if (resp && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_imem_fetch_router.sv
// Bench for imem_fetch_router: table-driven decode vectors, hand-written corner sequences, randomized traffic.
// Latency: ITCM source answers one cycle after access; IAXI source answers after a programmable latency, in order.
// Backpressure: IAXI_ready is driven per cycle; the in-flight queue model predicts pc_ready.
module tb_imem_fetch_router;

  localparam int MAXO = 2;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] instr_read_data;
  logic        instr_read_data_valid;
  logic        instr_itcm_access;
  logic [31:0] instr_itcm_addr;
  logic [31:0] instr_itcm_read_data;
  logic        instr_itcm_read_data_valid;
  logic        itcm_auto_load;
  logic        IAXI_access;
  logic [31:0] IAXI_addr;
  logic        IAXI_ready;
  logic [31:0] IAXI_read_data;
  logic        IAXI_read_data_valid;

  logic        n_pc_ready, n_rd_vld, n_itcm_acc, n_iaxi_acc;
  logic [31:0] n_rd_dat, n_itcm_addr, n_iaxi_addr;

  imem_fetch_router #(.MAX_OUTSTANDING(MAXO)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .pc(pc), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .flush(flush), .instr_read_data(instr_read_data),
    .instr_read_data_valid(instr_read_data_valid), .instr_itcm_access(instr_itcm_access),
    .instr_itcm_addr(instr_itcm_addr), .instr_itcm_read_data(instr_itcm_read_data),
    .instr_itcm_read_data_valid(instr_itcm_read_data_valid), .itcm_auto_load(itcm_auto_load),
    .IAXI_access(IAXI_access), .IAXI_addr(IAXI_addr), .IAXI_ready(IAXI_ready),
    .IAXI_read_data(IAXI_read_data), .IAXI_read_data_valid(IAXI_read_data_valid));

  imem_fetch_router #(.HAS_ITCM(0), .MAX_OUTSTANDING(MAXO)) dut_n (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .pc(pc), .pc_valid(pc_valid),
    .pc_ready(n_pc_ready), .flush(flush), .instr_read_data(n_rd_dat),
    .instr_read_data_valid(n_rd_vld), .instr_itcm_access(n_itcm_acc),
    .instr_itcm_addr(n_itcm_addr), .instr_itcm_read_data(instr_itcm_read_data),
    .instr_itcm_read_data_valid(instr_itcm_read_data_valid), .itcm_auto_load(itcm_auto_load),
    .IAXI_access(n_iaxi_acc), .IAXI_addr(n_iaxi_addr), .IAXI_ready(IAXI_ready),
    .IAXI_read_data(IAXI_read_data), .IAXI_read_data_valid(IAXI_read_data_valid));

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int passed = 0;
  int total  = 0;

  // Reference model: ordered list of in-flight fetches and the two memory sources.
  typedef struct { bit is_itcm; logic [31:0] addr; bit drop; } ent_t;
  typedef struct { int due; logic [31:0] addr; } ax_t;
  ent_t        mq[$];
  ax_t         iq[$];
  bit          itcm_pend;
  logic [31:0] itcm_pend_addr;
  int          cyc;
  int          iaxi_lat;
  bit          stray;
  int          fwd_cnt;

  bit          s_rdy, s_itcm_acc, s_iaxi_acc, s_vld;
  logic [31:0] s_dat;
  int          s_cyc;

  function automatic logic [31:0] itcm_word(input logic [31:0] a);
    return a * 3 + 32'h1;
  endfunction

  function automatic logic [31:0] iaxi_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // ITCM occupies byte addresses [0, 0x10000).
  function automatic bit in_itcm(input logic [31:0] a);
    longint unsigned x;
    x = a;
    return x < 64'h1_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    else passed++;
  endtask

  // One clock cycle: present source data, check outputs against the model, advance the model.
  task automatic step();
    bit t_itcm, exp_rdy, resp, exp_fwd, iaxi_real, issue;
    logic [31:0] exp_dat;
    int n, due;
    instr_itcm_read_data_valid = itcm_pend;
    instr_itcm_read_data       = itcm_pend ? itcm_word(itcm_pend_addr) : 32'h1357_9BDF;
    iaxi_real = !itcm_auto_load && iq.size() > 0 && iq[0].due <= cyc;
    if (itcm_auto_load) begin
      IAXI_read_data_valid = stray;
      IAXI_read_data       = 32'hDEAD_BEEF;
    end else begin
      IAXI_read_data_valid = iaxi_real;
      IAXI_read_data       = iaxi_real ? iaxi_word(iq[0].addr) : 32'h0BAD_0BAD;
    end
    #1;
    n       = mq.size();
    t_itcm  = in_itcm(pc);
    exp_rdy = !flush && !itcm_auto_load && n < MAXO && (n == 0 || mq[0].is_itcm == t_itcm)
              && (t_itcm || IAXI_ready);
    resp    = n > 0 && (mq[0].is_itcm ? instr_itcm_read_data_valid
                                     : (IAXI_read_data_valid && !itcm_auto_load));
    exp_fwd = resp && !mq[0].drop && !flush;
    exp_dat = 32'h0;
    if (exp_fwd) exp_dat = mq[0].is_itcm ? itcm_word(mq[0].addr) : iaxi_word(mq[0].addr);
    issue   = pc_valid && exp_rdy;
    chk("pc_ready", pc_ready, exp_rdy);
    chk("itcm_access", instr_itcm_access, issue && t_itcm);
    chk("iaxi_access", IAXI_access, issue && !t_itcm);
    chk("rd_valid", instr_read_data_valid, exp_fwd);
    chk("rd_data", instr_read_data, exp_dat);
    if (issue) chk("addr", t_itcm ? instr_itcm_addr : IAXI_addr, pc);
    s_rdy = pc_ready; s_itcm_acc = instr_itcm_access; s_iaxi_acc = IAXI_access;
    s_vld = instr_read_data_valid; s_dat = instr_read_data; s_cyc = cyc;
    if (s_vld) fwd_cnt++;
    @(posedge cpu_clk);
    if (resp) void'(mq.pop_front());
    if (flush) foreach (mq[i]) mq[i].drop = 1'b1;
    if (issue) mq.push_back('{is_itcm: t_itcm, addr: pc, drop: 1'b0});
    itcm_pend      = issue && t_itcm;
    itcm_pend_addr = pc;
    if (iaxi_real) void'(iq.pop_front());
    if (issue && !t_itcm) begin
      due = cyc + iaxi_lat;
      if (iq.size() > 0 && due <= iq[$].due) due = iq[$].due + 1;
      iq.push_back('{due: due, addr: pc});
    end
    cyc++;
    @(negedge cpu_clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (mq.size() == 0 && iq.size() == 0 && !itcm_pend) break;
      step();
    end
    chk("drain_done", (mq.size() == 0 && iq.size() == 0 && !itcm_pend), 1);
  endtask

  typedef struct { logic [31:0] pc; bit ardy; bit exp_rdy; bit exp_itcm; } vec_t;
  vec_t vecs[6];

  initial begin
    int f0, issues, r_cyc, i_cyc;
    vecs[0] = '{32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'h0000_FFFC, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{32'h0001_0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_1000, 1'b0, 1'b1, 1'b1};

    cpu_rstn = 1'b0; pc = 32'h0; pc_valid = 1'b1; flush = 1'b0; itcm_auto_load = 1'b0;
    IAXI_ready = 1'b1; instr_itcm_read_data = 32'h0; instr_itcm_read_data_valid = 1'b0;
    IAXI_read_data = 32'h0; IAXI_read_data_valid = 1'b0;
    itcm_pend = 1'b0; itcm_pend_addr = 32'h0; cyc = 0; iaxi_lat = 2; stray = 1'b0; fwd_cnt = 0;
    repeat (2) @(negedge cpu_clk);
    #1;
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_itcm_access", instr_itcm_access, 0);
    chk("rst_iaxi_access", IAXI_access, 0);
    chk("rst_rd_valid", instr_read_data_valid, 0);
    chk("rst_rd_data", instr_read_data, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    #1;
    // HAS_ITCM = 0: address 0 goes to IAXI. pc_valid is withdrawn before the next edge.
    chk("noitcm_pc_ready", n_pc_ready, 1);
    chk("noitcm_iaxi_access", n_iaxi_acc, 1);
    chk("noitcm_itcm_access", n_itcm_acc, 0);
    chk("noitcm_iaxi_addr", n_iaxi_addr, 32'h0);
    chk("noitcm_itcm_addr", n_itcm_addr, 32'h0);
    chk("noitcm_rd_valid", n_rd_vld, 0);
    chk("noitcm_rd_data", n_rd_dat, 32'h0);
    pc_valid = 1'b0;
    @(negedge cpu_clk);

    // Decode table from idle, including range boundaries and the address-space top.
    for (int i = 0; i < 6; i++) begin
      pc = vecs[i].pc; pc_valid = 1'b1; IAXI_ready = vecs[i].ardy;
      step();
      chk($sformatf("vec%0d_ready", i), s_rdy, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_itcm", i), s_itcm_acc, vecs[i].exp_rdy && vecs[i].exp_itcm);
      chk($sformatf("vec%0d_iaxi", i), s_iaxi_acc, vecs[i].exp_rdy && !vecs[i].exp_itcm);
      pc_valid = 1'b0; IAXI_ready = 1'b1;
      drain();
    end

    // ITCM streaming: three back-to-back fetches, data one cycle later each.
    pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      step();
      chk("stream_ready", s_rdy, 1);
      chk("stream_access", s_itcm_acc, 1);
      if (i > 0) begin
        chk("stream_vld", s_vld, 1);
        chk("stream_dat", s_dat, itcm_word(32'(4 * (i - 1))));
      end
    end
    pc_valid = 1'b0;
    step();
    chk("stream_vld_last", s_vld, 1);
    chk("stream_dat_last", s_dat, itcm_word(32'h8));
    drain();

    // IAXI back-pressure with 10-cycle latency.
    iaxi_lat = 10; issues = 0; i_cyc = -1; r_cyc = -1;
    pc = 32'h8000_0000; pc_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_iaxi_acc) begin issues++; if (i_cyc < 0) i_cyc = s_cyc; end
      if (s_vld) begin r_cyc = s_cyc; break; end
    end
    chk("bp_issues", issues, 2);
    chk("bp_first_resp_latency", r_cyc - i_cyc, 10);
    pc_valid = 1'b0;
    drain();

    // Target switch: ITCM fetch waits for the IAXI read to return.
    iaxi_lat = 5; r_cyc = -1; i_cyc = -1;
    pc = 32'h8000_0040; pc_valid = 1'b1;
    step();
    pc = 32'h0000_0100;
    for (int k = 0; k < 30; k++) begin
      step();
      if (s_vld) r_cyc = s_cyc;
      if (s_itcm_acc) begin i_cyc = s_cyc; break; end
    end
    chk("switch_after_drain", i_cyc - r_cyc, 1);
    pc_valid = 1'b0;
    drain();

    // Flush with two IAXI reads in flight: both responses are swallowed.
    iaxi_lat = 6;
    pc = 32'h8000_0080; pc_valid = 1'b1;
    step(); step();
    pc_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    f0 = fwd_cnt;
    drain();
    chk("flush_dropped", fwd_cnt, f0);
    pc = 32'h0000_0200; pc_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin step(); if (s_itcm_acc) break; end
    pc_valid = 1'b0;
    drain();
    chk("flush_next_fetch", fwd_cnt, f0 + 1);

    // Auto-load: no issue, stray IAXI data ignored, count preserved.
    iaxi_lat = 3;
    pc = 32'h8000_00C0; pc_valid = 1'b1;
    step();
    f0 = fwd_cnt;
    itcm_auto_load = 1'b1; stray = 1'b1; pc = 32'h0000_0300;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("al_ready", s_rdy, 0);
      chk("al_strobes", {s_itcm_acc, s_iaxi_acc}, 2'b00);
      chk("al_vld", s_vld, 0);
    end
    itcm_auto_load = 1'b0; stray = 1'b0; pc_valid = 1'b0;
    drain();
    chk("al_count_kept", fwd_cnt, f0 + 1);

    // Mid-flight reset: outputs clear at once, late IAXI data is ignored.
    iaxi_lat = 10;
    pc = 32'h8000_0010; pc_valid = 1'b1;
    step(); step();
    cpu_rstn = 1'b0;
    #1;
    chk("mrst_pc_ready", pc_ready, 0);
    chk("mrst_strobes", {instr_itcm_access, IAXI_access}, 2'b00);
    chk("mrst_rd_valid", instr_read_data_valid, 0);
    chk("mrst_rd_data", instr_read_data, 0);
    repeat (2) @(negedge cpu_clk);
    pc_valid = 1'b0;
    cpu_rstn = 1'b1;
    mq.delete();
    f0 = fwd_cnt;
    drain();
    chk("mrst_late_ignored", fwd_cnt, f0);

    // Randomized traffic against the queue model.
    for (int k = 0; k < 500; k++) begin
      case ($urandom_range(0, 5))
        0, 1: pc = {16'h0, 14'($urandom), 2'b00};
        2:    pc = 32'h8000_0000 | {20'h0, 10'($urandom), 2'b00};
        3:    pc = 32'h0000_FFFC;
        4:    pc = 32'h0001_0000;
        default: pc = 32'hFFFF_FFFC;
      endcase
      pc_valid       = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      itcm_auto_load = ($urandom_range(0, 19) == 0);
      stray          = $urandom_range(0, 1) != 0;
      IAXI_ready     = ($urandom_range(0, 4) != 0);
      iaxi_lat       = $urandom_range(1, 6);
      step();
    end
    pc_valid = 1'b0; flush = 1'b0; itcm_auto_load = 1'b0; stray = 1'b0; IAXI_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_fetch_router.md
Name: imem_fetch_router

Overview:
Parametrised instruction-fetch router between the fetch stage and two instruction sources: the ITCM, with a fixed 1-cycle read latency, and the IAXI master, with variable latency. It adds three things to single-request address steering:
- a valid/ready fetch handshake;
- up to MAX_OUTSTANDING in-flight requests, with responses returned in order;
- flush (redirect) support that silently discards stale responses.

Parameters:
ADDR_WIDTH, 32, fetch address width
INSTR_WIDTH, 32, instruction width
HAS_ITCM, 1, 0 = every fetch is routed to IAXI
ITCM_START_ADDR, 32'h0000_0000, ITCM base address
ITCM_SIZE, 32'h0001_0000, ITCM size in bytes
MAX_OUTSTANDING, 2, maximum in-flight fetches (1..7)

Ports:
cpu_clk  in  1  cpu clock
cpu_rstn  in  1  asynchronous active-low reset
pc  in  ADDR_WIDTH  fetch address
pc_valid  in  1  fetch request valid
pc_ready  out  1  fetch request accepted this cycle when high together with pc_valid
flush  in  1  pipeline redirect; discards all in-flight fetches
instr_read_data  out  INSTR_WIDTH  returned instruction
instr_read_data_valid  out  1  returned instruction valid (1-cycle pulse)
instr_itcm_access  out  1  ITCM read strobe
instr_itcm_addr  out  ADDR_WIDTH  ITCM read address
instr_itcm_read_data  in  INSTR_WIDTH  ITCM read data
instr_itcm_read_data_valid  in  1  ITCM read data valid
itcm_auto_load  in  1  ITCM auto-load in progress
IAXI_access  out  1  IAXI read strobe
IAXI_addr  out  ADDR_WIDTH  IAXI read address
IAXI_ready  in  1  IAXI can accept a request this cycle
IAXI_read_data  in  INSTR_WIDTH  IAXI read data
IAXI_read_data_valid  in  1  IAXI read data valid

Behaviour:
- Clock and reset: single clock cpu_clk; reset cpu_rstn is asynchronous, active-low.
- Reset values:
  - registers: out_cnt = 0, drop_cnt = 0, cur_tgt = ITCM.
  - outputs: all strobes, valids and data are 0; pc_ready is 0 while in reset.
- Decode:
  - tgt_itcm = HAS_ITCM && (pc >= ITCM_START_ADDR) && (pc < ITCM_START_ADDR + ITCM_SIZE).
  - Otherwise the target is IAXI.
  - The range compare is done at ADDR_WIDTH+1 bits so that it does not wrap at the top of the address space.
- pc_ready = !flush && !itcm_auto_load && (out_cnt < MAX_OUTSTANDING) && (out_cnt == 0 || tgt == cur_tgt) && (tgt_itcm || IAXI_ready).
  - A request to a different target stalls until all in-flight fetches have drained. This guarantees in-order return without a reorder buffer.
- Issue = pc_valid && pc_ready. The issue cycle drives:
  - instr_itcm_access = issue && tgt_itcm;
  - IAXI_access = issue && !tgt_itcm;
  - both address outputs = pc, combinationally;
  - cur_tgt <= tgt.
- Response:
  - resp = (out_cnt != 0) && (cur_tgt == ITCM ? instr_itcm_read_data_valid : (IAXI_read_data_valid && !itcm_auto_load)).
  - A response while out_cnt == 0 is ignored.
  - IAXI data received during itcm_auto_load belongs to the loader and is ignored.
- Counter update, every cycle: out_cnt <= out_cnt + issue - resp.
  - Issue and response in the same cycle leave the count unchanged.
  - The counter width is clog2(MAX_OUTSTANDING+1).
- Discard:
  - If resp && drop_cnt != 0, then drop_cnt decrements and the response is not forwarded.
  - Forwarding: instr_read_data_valid = resp && drop_cnt == 0 && !flush.
  - instr_read_data = source data when instr_read_data_valid is high, else 0.
- Flush:
  - drop_cnt <= out_cnt - resp. A response arriving in the flush cycle itself is consumed and dropped.
  - No issue happens in the flush cycle.
  - Fetches are accepted again in the next cycle. New fetches may target either source only after the pending fetches have drained, which follows from the target-switch rule.
- Invariants: drop_cnt <= out_cnt at all times; out_cnt never exceeds MAX_OUTSTANDING.
- Mid-operation reset: all counters clear immediately and in-flight responses after reset are ignored, because out_cnt == 0.

Test Plan:
- ITCM streaming: pc_valid held with pc = 0x0, 0x4, 0x8 and MAX_OUTSTANDING = 2 -> pc_ready stays 1, three instr_itcm_access pulses, instr_read_data_valid one cycle after each, data in order.
- IAXI back-pressure: pc = 0x8000_0000 with 10-cycle IAXI latency -> two accesses issued, then pc_ready = 0 until the first IAXI_read_data_valid; data returned in order.
- Target switch: IAXI fetch in flight, then pc = 0x100 (ITCM) -> pc_ready = 0 until the IAXI response; ITCM access is issued in the cycle after out_cnt reaches 0.
- Flush: two IAXI fetches in flight, then flush -> drop_cnt = 2, both later responses suppressed (instr_read_data_valid stays 0); the next fetch to 0x200 returns normally.
- Auto-load: itcm_auto_load = 1 with pc_valid = 1 and a stray IAXI_read_data_valid -> pc_ready = 0, no access strobes, no instr_read_data_valid, out_cnt unchanged.
- HAS_ITCM = 0 and reset: pc = 0x0 -> IAXI_access = 1; asserting cpu_rstn = 0 mid-flight -> all outputs 0 immediately, and a later IAXI_read_data_valid is ignored.
